// File: rtl/sram_dp_arbiter.sv
// Round-robin two-port arbiter/sequencer for one sram_dp_hde dual-port macro.
// Grants up to two requesters per cycle (A then B), suppresses same-address write collisions.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BITS
`define BITS 8
`endif

module sram_dp_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = `ADDR_WIDTH,
  parameter int DW    = `BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [N_REQ*DW-1:0] rsp_rdata,
  output logic                CENA,
  output logic                WENA,
  output logic [AW-1:0]       AA,
  output logic [DW-1:0]       DA,
  input  logic [DW-1:0]       QA,
  output logic                CENB,
  output logic                WENB,
  output logic [AW-1:0]       AB,
  output logic [DW-1:0]       DB,
  input  logic [DW-1:0]       QB,
  output logic [15:0]         coll_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [PW-1:0] idx_t;

  function automatic idx_t wrap_idx(input idx_t base, input int step);
    int j;
    j = int'(base) + step;
    if (j >= N_REQ) j = j - N_REQ;
    return idx_t'(j);
  endfunction

  idx_t          ptr_q, ptr_d, scan_idx, idx_a, idx_b, last_idx;
  logic          gnt_a, gnt_b, gnt_b_ok, coll;
  logic          we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [15:0]   coll_cnt_q, coll_cnt_d;

  logic          cena_q, wena_q, cenb_q, wenb_q;
  logic [AW-1:0] aa_q, ab_q;
  logic [DW-1:0] da_q, db_q;

  // Read return pipeline per port: stage 1 = macro access cycle, stage 2 = data cycle.
  logic          va1_q, va2_q, vb1_q, vb2_q;
  idx_t          ida1_q, ida2_q, idb1_q, idb2_q;

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = wrap_idx(ptr_q, k);
      if (req_valid[scan_idx]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          idx_a = scan_idx;
        end else if (!gnt_b) begin
          gnt_b = 1'b1;
          idx_b = scan_idx;
        end
      end
    end
  end

  assign we_a    = req_we[idx_a];
  assign we_b    = req_we[idx_b];
  assign addr_a  = req_addr[idx_a*AW +: AW];
  assign addr_b  = req_addr[idx_b*AW +: AW];
  assign wdata_a = req_wdata[idx_a*DW +: DW];
  assign wdata_b = req_wdata[idx_b*DW +: DW];

  // Two reads of one address are harmless; anything involving a write defers port B.
  assign coll     = gnt_a && gnt_b && (addr_a == addr_b) && (we_a || we_b);
  assign gnt_b_ok = gnt_b && !coll;

  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (gnt_a)    req_ready[idx_a] = 1'b1;
      if (gnt_b_ok) req_ready[idx_b] = 1'b1;
    end
  end

  assign last_idx   = gnt_b_ok ? idx_b : idx_a;
  assign ptr_d      = gnt_a ? wrap_idx(last_idx, 1) : ptr_q;
  assign coll_cnt_d = (coll && (coll_cnt_q != 16'hFFFF)) ? coll_cnt_q + 16'd1 : coll_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      coll_cnt_q <= '0;
      cena_q     <= 1'b1;
      wena_q     <= 1'b1;
      aa_q       <= '0;
      da_q       <= '0;
      cenb_q     <= 1'b1;
      wenb_q     <= 1'b1;
      ab_q       <= '0;
      db_q       <= '0;
      va1_q      <= 1'b0;
      va2_q      <= 1'b0;
      vb1_q      <= 1'b0;
      vb2_q      <= 1'b0;
      ida1_q     <= '0;
      ida2_q     <= '0;
      idb1_q     <= '0;
      idb2_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      coll_cnt_q <= coll_cnt_d;

      cena_q <= ~gnt_a;
      wena_q <= gnt_a ? ~we_a : 1'b1;
      if (gnt_a) begin
        aa_q <= addr_a;
        da_q <= wdata_a;
      end

      cenb_q <= ~gnt_b_ok;
      wenb_q <= gnt_b_ok ? ~we_b : 1'b1;
      if (gnt_b_ok) begin
        ab_q <= addr_b;
        db_q <= wdata_b;
      end

      va1_q  <= gnt_a & ~we_a;
      ida1_q <= idx_a;
      va2_q  <= va1_q;
      ida2_q <= ida1_q;
      vb1_q  <= gnt_b_ok & ~we_b;
      idb1_q <= idx_b;
      vb2_q  <= vb1_q;
      idb2_q <= idb1_q;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (va2_q) begin
      rsp_valid[ida2_q]            = 1'b1;
      rsp_rdata[ida2_q*DW +: DW]   = QA;
    end
    if (vb2_q) begin
      rsp_valid[idb2_q]            = 1'b1;
      rsp_rdata[idb2_q*DW +: DW]   = QB;
    end
  end

  assign CENA     = cena_q;
  assign WENA     = wena_q;
  assign AA       = aa_q;
  assign DA       = da_q;
  assign CENB     = cenb_q;
  assign WENB     = wenb_q;
  assign AB       = ab_q;
  assign DB       = db_q;
  assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Directed bench for sram_dp_arbiter with a behavioural dual-port memory on the macro pins.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.

module tb_sram_dp_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_rdata;
  logic            CENA, WENA, CENB, WENB;
  logic [AW-1:0]   AA, AB;
  logic [DW-1:0]   DA, DB;
  logic [DW-1:0]   qa = '0;
  logic [DW-1:0]   qb = '0;
  logic [15:0]     coll_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  sram_dp_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .CENA      (CENA),
    .WENA      (WENA),
    .AA        (AA),
    .DA        (DA),
    .QA        (qa),
    .CENB      (CENB),
    .WENB      (WENB),
    .AB        (AB),
    .DB        (DB),
    .QB        (qb),
    .coll_cnt  (coll_cnt)
  );

  always #5 clk = ~clk;

  // Macro model: synchronous read/write, data appears the cycle after the access.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (!CENA) begin
      if (!WENA) mem[AA] <= DA;
      else       qa <= mem[AA];
    end
    if (!CENB) begin
      if (!WENB) mem[AB] <= DB;
      else       qb <= mem[AB];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]            = v;
    req_we[i]               = we;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_req();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++;
    if ({CENA, WENA, CENB, WENB} !== 4'b1111) begin
      bad++; $display("FAIL reset_ctrl: got CENA/WENA/CENB/WENB=%b want 1111", {CENA, WENA, CENB, WENB});
    end
    total++;
    if ({AA, AB, DA, DB} !== '0) begin
      bad++; $display("FAIL reset_addr_data: got AA=%h AB=%h DA=%h DB=%h want all 0", AA, AB, DA, DB);
    end
    total++;
    if (rsp_valid !== '0 || rsp_rdata !== '0 || coll_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_rsp: got rsp_valid=%b rsp_rdata=%h coll_cnt=%0d want 0", rsp_valid, rsp_rdata, coll_cnt);
    end
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 8'h05, '0);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(negedge clk);
    clear_req();
    #1;
    total++;
    if (CENA !== 1'b0 || WENA !== 1'b1 || AA !== 8'h05 || CENB !== 1'b1) begin
      bad++; $display("FAIL single_portA: got CENA=%b WENA=%b AA=%h CENB=%b want 0 1 05 1", CENA, WENA, AA, CENB);
    end
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_early_rsp: got %b want 0000", rsp_valid); end
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
    total++;
    if (rsp_rdata !== 32'h00A5_0000) begin bad++; $display("FAIL single_rsp_data: got %h want 00a50000", rsp_rdata); end
  endtask

  task automatic test_all_four();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(8'h40 + i), '0);
    #1;
    total++;
    if (req_ready !== 4'b0011) begin bad++; $display("FAIL four_ready_c0: got %b want 0011", req_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (req_ready !== 4'b1100) begin bad++; $display("FAIL four_ready_c1: got %b want 1100", req_ready); end
    total++;
    if (CENA !== 1'b0 || AA !== 8'h40 || CENB !== 1'b0 || AB !== 8'h41) begin
      bad++; $display("FAIL four_ports_c1: got CENA=%b AA=%h CENB=%b AB=%h want 0 40 0 41", CENA, AA, CENB, AB);
    end
    @(negedge clk);
    clear_req();
    #1;
    total++;
    if (rsp_valid !== 4'b0011 || rsp_rdata !== 32'h0000_2211) begin
      bad++; $display("FAIL four_rsp_c2: got valid=%b data=%h want 0011 00002211", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 4'b1100 || rsp_rdata !== 32'h4433_0000) begin
      bad++; $display("FAIL four_rsp_c3: got valid=%b data=%h want 1100 44330000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 8'h10, 8'h3C);
    set_req(1, 1'b1, 1'b0, 8'h10, '0);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL coll_ready_c0: got %b want 0001", req_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (coll_cnt !== 16'd1) begin bad++; $display("FAIL coll_cnt_c1: got %0d want 1", coll_cnt); end
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL coll_ready_c1: got %b want 0010", req_ready); end
    total++;
    if (CENA !== 1'b0 || WENA !== 1'b0 || AA !== 8'h10 || DA !== 8'h3C || CENB !== 1'b1) begin
      bad++; $display("FAIL coll_write_c1: got CENA=%b WENA=%b AA=%h DA=%h CENB=%b want 0 0 10 3c 1", CENA, WENA, AA, DA, CENB);
    end
    @(negedge clk);
    clear_req();
    #1;
    total++;
    if (CENA !== 1'b0 || WENA !== 1'b1 || AA !== 8'h10) begin
      bad++; $display("FAIL coll_read_c2: got CENA=%b WENA=%b AA=%h want 0 1 10", CENA, WENA, AA);
    end
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'h0000_3C00) begin
      bad++; $display("FAIL coll_rsp_c3: got valid=%b data=%h want 0010 00003c00", rsp_valid, rsp_rdata);
    end
  endtask

  // Runs straight after test_collision: pointer is 2, coll_cnt is 1.
  task automatic test_shared_read();
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 8'h20, '0);
    set_req(3, 1'b1, 1'b0, 8'h20, '0);
    #1;
    total++;
    if (req_ready !== 4'b1010) begin bad++; $display("FAIL shared_ready: got %b want 1010", req_ready); end
    @(negedge clk);
    clear_req();
    #1;
    total++;
    if (CENA !== 1'b0 || AA !== 8'h20 || CENB !== 1'b0 || AB !== 8'h20) begin
      bad++; $display("FAIL shared_ports: got CENA=%b AA=%h CENB=%b AB=%h want 0 20 0 20", CENA, AA, CENB, AB);
    end
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 4'b1010 || rsp_rdata !== 32'h7700_7700) begin
      bad++; $display("FAIL shared_rsp: got valid=%b data=%h want 1010 77007700", rsp_valid, rsp_rdata);
    end
    total++;
    if (coll_cnt !== 16'd1) begin bad++; $display("FAIL shared_coll_cnt: got %0d want 1", coll_cnt); end
  endtask

  // All four write one address, so only port A grants and the pointer steps by one per cycle.
  task automatic test_fairness();
    logic [N-1:0] exp_ready [4];
    logic         granted2;
    exp_ready[0] = 4'b0001;
    exp_ready[1] = 4'b0010;
    exp_ready[2] = 4'b0100;
    exp_ready[3] = 4'b1000;
    granted2 = 1'b0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 8'h30, DW'(8'hC0 + i));
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (granted2) set_req(2, 1'b0, 1'b0, '0, '0);
      #1;
      total++;
      if (req_ready !== exp_ready[c]) begin
        bad++; $display("FAIL fair_ready_c%0d: got %b want %b", c, req_ready, exp_ready[c]);
      end
      total++;
      if (coll_cnt !== 16'(c)) begin bad++; $display("FAIL fair_coll_c%0d: got %0d want %0d", c, coll_cnt, c); end
      if (req_ready[2] && req_valid[2]) granted2 = 1'b1;
    end
    total++;
    if (!granted2) begin bad++; $display("FAIL fair_grant2: got no grant within 4 cycles want grant"); end
    @(negedge clk);
    clear_req();
    #1;
    total++;
    if (coll_cnt !== 16'd4) begin bad++; $display("FAIL fair_coll_end: got %0d want 4", coll_cnt); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h05, '0);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    clear_req();
    rst_n = 1'b0;
    #1;
    total++;
    if (CENA !== 1'b1 || WENA !== 1'b1 || AA !== 8'h00 || rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_vals: got CENA=%b WENA=%b AA=%h rsp_valid=%b want 1 1 00 0000", CENA, WENA, AA, rsp_valid);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 4'b0000 || rsp_rdata !== '0) begin
        bad++; $display("FAIL mid_no_rsp_%0d: got valid=%b data=%h want 0000 0", c, rsp_valid, rsp_rdata);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_after_release: got %b want 0000", rsp_valid); end
    set_req(1, 1'b1, 1'b0, 8'h05, '0);
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_resume_ready: got %b want 0010", req_ready); end
    @(negedge clk);
    clear_req();
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'h0000_A500) begin
      bad++; $display("FAIL mid_resume_rsp: got valid=%b data=%h want 0010 0000a500", rsp_valid, rsp_rdata);
    end
  endtask

  initial begin
    preload(8'h05, 8'hA5);
    preload(8'h40, 8'h11);
    preload(8'h41, 8'h22);
    preload(8'h42, 8'h33);
    preload(8'h43, 8'h44);
    preload(8'h10, 8'h00);
    preload(8'h20, 8'h77);
    test_reset();
    test_single_read();
    test_all_four();
    test_collision();
    test_shared_read();
    test_fairness();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
